// File: rtl/nibble_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_pkg
//  Purpose  : Shared constants and FSM state type for the nibble-serial adder.
//  Revision : 1.0 - initial release
// ============================================================================
package nibble_serial_pkg;

    // Width of one serial slice
    localparam int NIBBLE_W = 4;

    // Controller states; encodings are fixed so they stay stable across builds
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of serial steps needed for an operand of the given width
    function automatic int nibbles_for(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_add_4.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_add_4
//  Purpose  : Combinational 4-bit adder slice. Besides the sum and carry out
//             it exposes the carry into bit 3, so the caller can derive
//             two's-complement overflow for the top nibble.
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_add_4
    import nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                carry_out,
    output logic                carry_msb
);

    logic [NIBBLE_W:0]   full_sum;
    logic [NIBBLE_W-1:0] low_sum;

    // Full 5-bit sum plus a 3-bit partial sum whose top bit is the carry into bit 3
    always_comb begin
        full_sum  = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, carry_in};
        low_sum   = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]}
                  + {{(NIBBLE_W-1){1'b0}}, carry_in};
        sum       = full_sum[NIBBLE_W-1:0];
        carry_out = full_sum[NIBBLE_W];
        carry_msb = low_sum[NIBBLE_W-1];
    end

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder
//  Purpose  : Adds two WIDTH-bit operands one nibble per clock, LSB nibble
//             first, through a single 4-bit adder slice. Valid/ready
//             handshake on both input and output. WIDTH must be a multiple
//             of 4 and at least 8.
//  Options  : NSA_OVERFLOW_FLAG_EN - adds the 'overflow' output
//             (two's-complement overflow of the full-width add).
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef NSA_OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int                NIBBLES    = nibbles_for(WIDTH);
    localparam int                CNT_W      = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(NIBBLES - 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    count;
    logic                carry;
    logic [WIDTH-1:0]    a_sh;
    logic [WIDTH-1:0]    b_sh;

    logic                accept;
    logic                running;
    logic                last_step;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
`ifdef NSA_OVERFLOW_FLAG_EN
    logic                nib_cmsb;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign running   = (state == ST_RUN);
    assign last_step = (count == LAST_COUNT);

    // The one shared slice always sees the current low nibbles and the carry flop
    nibble_add_4 u_add (
        .a         (a_sh[NIBBLE_W-1:0]),
        .b         (b_sh[NIBBLE_W-1:0]),
        .carry_in  (carry),
        .sum       (nib_sum),
        .carry_out (nib_cout),
`ifdef NSA_OVERFLOW_FLAG_EN
        .carry_msb (nib_cmsb)
`else
        .carry_msb ()
`endif
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; operands are only looked at while idle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)               state_next = ST_RUN;
            ST_RUN:  if (last_step)            state_next = ST_DONE;
            ST_DONE: if (out_valid && out_ready) state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // Operand capture and serial datapath; sum/carry_out hold once RUN ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= carry_in;
            count <= '0;
        end else if (running) begin
            // New nibble enters at the top, so after NIBBLES steps nibble 0 sits at the bottom
            sum   <= {nib_sum, sum[WIDTH-1:NIBBLE_W]};
            carry <= nib_cout;
            a_sh  <= a_sh >> NIBBLE_W;
            b_sh  <= b_sh >> NIBBLE_W;
            count <= count + CNT_W'(1);
            if (last_step) begin
                carry_out <= nib_cout;
            end
        end
    end

`ifdef NSA_OVERFLOW_FLAG_EN
    // Overflow comes from the top nibble: carry into MSB differs from carry out of MSB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (running && last_step) begin
            overflow <= nib_cmsb ^ nib_cout;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_adder
//  Purpose  : Directed self-checking bench for nibble_serial_adder (WIDTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef NSA_OVERFLOW_FLAG_EN
    logic             overflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef NSA_OVERFLOW_FLAG_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete add with out_ready high; checks latency, result and return to IDLE
    task automatic run_add(input logic [15:0] av, input logic [15:0] bv, input logic cin,
                           input logic [15:0] exp_sum, input logic exp_c, input logic exp_ovf);
        chk("pre_in_ready", 32'(in_ready), 1);
        a = av; b = bv; carry_in = cin; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        for (int k = 0; k < NIBBLES; k++) begin
            chk("run_out_valid", 32'(out_valid), 0);
            chk("run_in_ready", 32'(in_ready), 0);
            step();
        end
        chk("done_out_valid", 32'(out_valid), 1);
        chk("done_sum", 32'(sum), 32'(exp_sum));
        chk("done_carry_out", 32'(carry_out), 32'(exp_c));
        chk("done_in_ready", 32'(in_ready), 0);
`ifdef NSA_OVERFLOW_FLAG_EN
        chk("done_overflow", 32'(overflow), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unexpected x flag");
`endif
        step();
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_sum_hold", 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; carry_in = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_carry_out", 32'(carry_out), 0);
`ifdef NSA_OVERFLOW_FLAG_EN
        chk("rst_overflow", 32'(overflow), 0);
`endif
        reset = 1'b0;
        step();

        // Basic adds and wrap / carry-in boundaries
        run_add(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_add(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Backpressure: hold result for 3 cycles, ignore in_valid in DONE
        a = 16'hABCD; b = 16'h1234; carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (NIBBLES) step();
        for (int k = 0; k < 3; k++) begin
            in_valid = (k == 0);
            a = 16'h0101; b = 16'h0202;
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_sum", 32'(sum), 'hBE01);
            chk("bp_carry_out", 32'(carry_out), 0);
            chk("bp_in_ready", 32'(in_ready), 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_release_valid", 32'(out_valid), 1);
        step();
        chk("bp_idle_in_ready", 32'(in_ready), 1);
        chk("bp_idle_out_valid", 32'(out_valid), 0);
        step();
        chk("bp_no_accept", 32'(in_ready), 1);
        chk("bp_sum_kept", 32'(sum), 'hBE01);

        // Reset during the second RUN cycle aborts the add
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("abort_sum", 32'(sum), 0);
        chk("abort_carry_out", 32'(carry_out), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("abort_no_valid", 32'(out_valid), 0);
        end
        chk("abort_idle", 32'(in_ready), 1);

        // Back-to-back with in_valid and out_ready held high
        a = 16'h0F0F; b = 16'h00F1; carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        a = 16'h8000; b = 16'h8000;
        chk("b2b_accept1", 32'(in_ready), 0);
        repeat (NIBBLES) step();
        chk("b2b_valid1", 32'(out_valid), 1);
        chk("b2b_sum1", 32'(sum), 'h1000);
        chk("b2b_c1", 32'(carry_out), 0);
        step();
        chk("b2b_idle", 32'(in_ready), 1);
        step();
        chk("b2b_accept2", 32'(in_ready), 0);
        in_valid = 1'b0;
        for (int k = 0; k < NIBBLES - 1; k++) begin
            step();
            chk("b2b_run2_valid", 32'(out_valid), 0);
        end
        step();
        chk("b2b_valid2", 32'(out_valid), 1);
        chk("b2b_sum2", 32'(sum), 'h0000);
        chk("b2b_c2", 32'(carry_out), 1);
`ifdef NSA_OVERFLOW_FLAG_EN
        chk("b2b_ovf2", 32'(overflow), 1);
`endif
        step();
        chk("b2b_end_idle", 32'(in_ready), 1);

        // Signed overflow boundary
        run_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
